// File: rtl/f1_itlb_pkg.sv
// Shared front-end definitions for the instruction TLB: walk FSM encoding
// and width helpers derived from the address parameters.
package f1_itlb_pkg;

   typedef enum logic [1:0] {
      WALK_IDLE = 2'd0,
      WALK_REQ  = 2'd1,
      WALK_WAIT = 2'd2
   } walk_state_e;

   // Bits below the cache-line address (byte offset inside a line).
   function automatic int line_width(input int xlen, input int clc_width);
      return xlen - clc_width;
   endfunction

   // Width of a virtual or physical page number.
   function automatic int vpn_width(input int xlen, input int page_bits);
      return xlen - page_bits;
   endfunction

endpackage

// File: rtl/f1_itlb_if.sv
// Page-walk port of the instruction TLB: valid/ready request towards the
// walker, single-cycle response pulse back.
interface f1_itlb_if #(
   parameter int VPN_W = 20
);
   logic             walk_req_valid;
   logic             walk_req_ready;
   logic [VPN_W-1:0] walk_req_vpn;
   logic             walk_resp_valid;
   logic [VPN_W-1:0] walk_resp_ppn;
   logic             walk_resp_pcd;
   logic             walk_resp_fault;

   // TLB side issues requests and consumes responses.
   modport master (
      output walk_req_valid, walk_req_vpn,
      input  walk_req_ready, walk_resp_valid, walk_resp_ppn,
             walk_resp_pcd, walk_resp_fault
   );

   // Walker side serves requests and produces responses.
   modport slave (
      input  walk_req_valid, walk_req_vpn,
      output walk_req_ready, walk_resp_valid, walk_resp_ppn,
             walk_resp_pcd, walk_resp_fault
   );
endinterface

// File: rtl/f1_itlb_cam.sv
// Fully associative translation store: two parallel lookup ports and one
// install port. Victim is the lowest free entry, otherwise a round-robin
// pointer that only advances when a live entry is overwritten.
module itlb_cam #(
   parameter int ENTRIES = 8,
   parameter int VPN_W   = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic [VPN_W-1:0] rd_vpn_a,
   output logic             rd_hit_a,
   output logic [VPN_W-1:0] rd_ppn_a,
   output logic             rd_pcd_a,
   input  logic [VPN_W-1:0] rd_vpn_b,
   output logic             rd_hit_b,
   output logic [VPN_W-1:0] rd_ppn_b,
   output logic             rd_pcd_b,
   input  logic             wr_en,
   input  logic [VPN_W-1:0] wr_vpn,
   input  logic [VPN_W-1:0] wr_ppn,
   input  logic             wr_pcd
);
   localparam int IDX_W = $clog2(ENTRIES);

   logic [ENTRIES-1:0] valid;
   logic [VPN_W-1:0]   tag [ENTRIES];
   logic [VPN_W-1:0]   ppn [ENTRIES];
   logic [ENTRIES-1:0] pcd;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   victim;
   logic [ENTRIES-1:0] match_a;
   logic [ENTRIES-1:0] match_b;

   // Match both lookup ports; at most one entry matches, so OR-merging is exact.
   always_comb begin
      match_a  = '0;
      match_b  = '0;
      rd_ppn_a = '0;
      rd_ppn_b = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         match_a[i] = valid[i] & (tag[i] == rd_vpn_a);
         match_b[i] = valid[i] & (tag[i] == rd_vpn_b);
         rd_ppn_a   = rd_ppn_a | ({VPN_W{match_a[i]}} & ppn[i]);
         rd_ppn_b   = rd_ppn_b | ({VPN_W{match_b[i]}} & ppn[i]);
      end
      rd_hit_a = |match_a;
      rd_hit_b = |match_b;
      rd_pcd_a = |(match_a & pcd);
      rd_pcd_b = |(match_b & pcd);
   end

   // Pick the lowest-index free entry, falling back to the round-robin pointer.
   always_comb begin
      victim = rr_ptr;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         victim = valid[i] ? victim : IDX_W'(i);
      end
   end

   // Valid bits and replacement pointer; flush wipes both.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid  <= '0;
         rr_ptr <= '0;
      end else if (flush) begin
         valid  <= '0;
         rr_ptr <= '0;
      end else if (wr_en) begin
         valid[victim] <= 1'b1;
         if (&valid) begin
            rr_ptr <= rr_ptr + IDX_W'(1);
         end
      end
   end

   // Translation payload; contents are meaningless while the valid bit is clear.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag[victim] <= wr_vpn;
         ppn[victim] <= wr_ppn;
         pcd[victim] <= wr_pcd;
      end
   end

endmodule

// File: rtl/f1_itlb.sv
// Instruction TLB for the fetch stage: translates an even/odd cache-line
// pair per request, walks missing pages one at a time, latches faults.
module f1_itlb
   import f1_itlb_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int CLC_WIDTH = 28,
   parameter int PAGE_BITS = 12,
   parameter int ENTRIES   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid_in,
   input  logic [CLC_WIDTH-1:0] clc_even_in,
   input  logic [CLC_WIDTH-1:0] clc_odd_in,
   input  logic                 stall_in,
   input  logic                 flush_in,
   output logic                 ready_out,
   output logic                 addr_even_valid,
   output logic                 addr_odd_valid,
   output logic [XLEN-1:0]      addr_even,
   output logic [XLEN-1:0]      addr_odd,
   output logic                 hit,
   output logic                 pcd,
   output logic                 exception,
   f1_itlb_if.master            walk
);
   localparam int LINE_W = line_width(XLEN, CLC_WIDTH);
   localparam int VPN_W  = vpn_width(XLEN, PAGE_BITS);
   localparam int OFF_W  = PAGE_BITS - LINE_W;

   walk_state_e      state;
   logic [VPN_W-1:0] walk_vpn;
   logic             req_valid;
   logic             fault;

   logic [VPN_W-1:0] vpn_even;
   logic [VPN_W-1:0] vpn_odd;
   logic             hit_even;
   logic             hit_odd;
   logic [VPN_W-1:0] ppn_even;
   logic [VPN_W-1:0] ppn_odd;
   logic             pcd_even;
   logic             pcd_odd;
   logic             both_hit;
   logic             accept;
   logic             install;

   assign vpn_even = clc_even_in[CLC_WIDTH-1 -: VPN_W];
   assign vpn_odd  = clc_odd_in[CLC_WIDTH-1 -: VPN_W];
   assign both_hit = hit_even & hit_odd;

   // A request is taken only when both lines translate and nothing blocks it.
   assign accept    = (state == WALK_IDLE) & valid_in & ~stall_in & ~flush_in
                      & both_hit & ~fault;
   assign ready_out = accept;
   assign install   = (state == WALK_WAIT) & walk.walk_resp_valid
                      & ~walk.walk_resp_fault & ~flush_in;

   assign walk.walk_req_valid = req_valid;
   assign walk.walk_req_vpn   = walk_vpn;
   assign exception           = fault;

   itlb_cam #(
      .ENTRIES (ENTRIES),
      .VPN_W   (VPN_W)
   ) u_cam (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush_in),
      .rd_vpn_a (vpn_even),
      .rd_hit_a (hit_even),
      .rd_ppn_a (ppn_even),
      .rd_pcd_a (pcd_even),
      .rd_vpn_b (vpn_odd),
      .rd_hit_b (hit_odd),
      .rd_ppn_b (ppn_odd),
      .rd_pcd_b (pcd_odd),
      .wr_en    (install),
      .wr_vpn   (walk_vpn),
      .wr_ppn   (walk.walk_resp_ppn),
      .wr_pcd   (walk.walk_resp_pcd)
   );

   // Page-walk sequencer: even page first, one outstanding walk, fault latch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= WALK_IDLE;
         walk_vpn  <= '0;
         req_valid <= 1'b0;
         fault     <= 1'b0;
      end else if (flush_in) begin
         state     <= WALK_IDLE;
         req_valid <= 1'b0;
         fault     <= 1'b0;
      end else begin
         case (state)
            WALK_IDLE: begin
               if (valid_in && !both_hit && !fault) begin
                  walk_vpn  <= hit_even ? vpn_odd : vpn_even;
                  req_valid <= 1'b1;
                  state     <= WALK_REQ;
               end
            end
            WALK_REQ: begin
               if (walk.walk_req_ready) begin
                  req_valid <= 1'b0;
                  state     <= WALK_WAIT;
               end
            end
            WALK_WAIT: begin
               if (walk.walk_resp_valid) begin
                  fault <= walk.walk_resp_fault;
                  state <= WALK_IDLE;
               end
            end
            default: begin
               req_valid <= 1'b0;
               state     <= WALK_IDLE;
            end
         endcase
      end
   end

   // Fetch-side result registers; a stall freezes them, any idle cycle drops valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_even_valid <= 1'b0;
         addr_odd_valid  <= 1'b0;
         hit             <= 1'b0;
         pcd             <= 1'b0;
         addr_even       <= '0;
         addr_odd        <= '0;
      end else if (flush_in) begin
         addr_even_valid <= 1'b0;
         addr_odd_valid  <= 1'b0;
         hit             <= 1'b0;
      end else if (stall_in) begin
         addr_even_valid <= addr_even_valid;
         addr_odd_valid  <= addr_odd_valid;
      end else if (accept) begin
         addr_even_valid <= 1'b1;
         addr_odd_valid  <= 1'b1;
         hit             <= 1'b1;
         pcd             <= pcd_even | pcd_odd;
         addr_even       <= {ppn_even, clc_even_in[OFF_W-1:0], {LINE_W{1'b0}}};
         addr_odd        <= {ppn_odd, clc_odd_in[OFF_W-1:0], {LINE_W{1'b0}}};
      end else begin
         addr_even_valid <= 1'b0;
         addr_odd_valid  <= 1'b0;
         hit             <= 1'b0;
      end
   end

endmodule

// File: tb/tb_f1_itlb.sv
// Directed bench for f1_itlb: a page-table model answers walks, expected
// walk VPNs and translated outputs are queued and checked as they appear.
module tb_f1_itlb;
   localparam int XLEN      = 32;
   localparam int CLC_WIDTH = 28;
   localparam int PAGE_BITS = 12;
   localparam int ENTRIES   = 4;
   localparam int VPN_W     = 20;

   typedef struct packed {
      logic [31:0] ae;
      logic [31:0] ao;
      logic        pcd;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        valid_in;
   logic [27:0] clc_even_in;
   logic [27:0] clc_odd_in;
   logic        stall_in;
   logic        flush_in;
   logic        ready_out;
   logic        addr_even_valid;
   logic        addr_odd_valid;
   logic [31:0] addr_even;
   logic [31:0] addr_odd;
   logic        hit;
   logic        pcd;
   logic        exception;

   f1_itlb_if #(.VPN_W(VPN_W)) walk_if ();

   f1_itlb #(
      .XLEN      (XLEN),
      .CLC_WIDTH (CLC_WIDTH),
      .PAGE_BITS (PAGE_BITS),
      .ENTRIES   (ENTRIES)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .valid_in        (valid_in),
      .clc_even_in     (clc_even_in),
      .clc_odd_in      (clc_odd_in),
      .stall_in        (stall_in),
      .flush_in        (flush_in),
      .ready_out       (ready_out),
      .addr_even_valid (addr_even_valid),
      .addr_odd_valid  (addr_odd_valid),
      .addr_even       (addr_even),
      .addr_odd        (addr_odd),
      .hit             (hit),
      .pcd             (pcd),
      .exception       (exception),
      .walk            (walk_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t        sb[$];
   logic [19:0] walk_exp[$];
   exp_t        last_exp;
   int          total = 0;
   int          bad   = 0;

   // Page-table model used by the bench walker.
   function automatic logic [19:0] ppn_of(input logic [19:0] vpn);
      return (vpn == 20'h00123) ? 20'h000AB : (vpn + 20'h10000);
   endfunction

   function automatic logic pcd_of(input logic [19:0] vpn);
      return vpn[0];
   endfunction

   function automatic logic fault_of(input logic [19:0] vpn);
      return vpn == 20'h00200;
   endfunction

   function automatic logic [31:0] phys(input logic [27:0] clc);
      return {ppn_of(clc[27:8]), clc[7:0], 4'h0};
   endfunction

   function automatic logic [27:0] line_of(input logic [19:0] page, input logic [7:0] off);
      return {page, off};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_flush();
      flush_in = 1'b1;
      tick();
      flush_in = 1'b0;
   endtask

   // Present a request, serve any walks from the model, check the result.
   task automatic lookup(input logic [27:0] e, input logic [27:0] o, output logic faulted);
      logic        done;
      logic [19:0] vpn;
      exp_t        x;
      exp_t        got;
      done        = 1'b0;
      faulted     = 1'b0;
      valid_in    = 1'b1;
      clc_even_in = e;
      clc_odd_in  = o;
      for (int cyc = 0; cyc < 100 && !done; cyc++) begin
         #1;
         if (ready_out) begin
            x.ae  = phys(e);
            x.ao  = phys(o);
            x.pcd = pcd_of(e[27:8]) | pcd_of(o[27:8]);
            sb.push_back(x);
            tick();
            valid_in = 1'b0;
            got = sb.pop_front();
            chk("out_valids", {30'd0, addr_even_valid, addr_odd_valid}, 32'd3);
            chk("out_hit", {31'd0, hit}, 32'd1);
            chk("out_addr_even", addr_even, got.ae);
            chk("out_addr_odd", addr_odd, got.ao);
            chk("out_pcd", {31'd0, pcd}, {31'd0, got.pcd});
            last_exp = got;
            done = 1'b1;
         end else if (walk_if.walk_req_valid) begin
            vpn = walk_if.walk_req_vpn;
            chk("walk_expected", {31'd0, walk_exp.size() != 0}, 32'd1);
            if (walk_exp.size() != 0) begin
               chk("walk_vpn", {12'd0, vpn}, {12'd0, walk_exp.pop_front()});
            end
            walk_if.walk_req_ready = 1'b1;
            tick();
            walk_if.walk_req_ready  = 1'b0;
            tick();
            walk_if.walk_resp_valid = 1'b1;
            walk_if.walk_resp_ppn   = ppn_of(vpn);
            walk_if.walk_resp_pcd   = pcd_of(vpn);
            walk_if.walk_resp_fault = fault_of(vpn);
            tick();
            walk_if.walk_resp_valid = 1'b0;
            walk_if.walk_resp_fault = 1'b0;
            if (fault_of(vpn)) begin
               faulted = 1'b1;
               done    = 1'b1;
            end
         end else begin
            tick();
         end
      end
      chk("lookup_finished", {31'd0, done}, 32'd1);
      chk("walks_remaining", walk_exp.size(), 32'd0);
      valid_in = 1'b0;
   endtask

   initial begin
      logic f;
      rst         = 1'b1;
      valid_in    = 1'b0;
      clc_even_in = '0;
      clc_odd_in  = '0;
      stall_in    = 1'b0;
      flush_in    = 1'b0;
      walk_if.walk_req_ready  = 1'b0;
      walk_if.walk_resp_valid = 1'b0;
      walk_if.walk_resp_ppn   = '0;
      walk_if.walk_resp_pcd   = 1'b0;
      walk_if.walk_resp_fault = 1'b0;

      // Reset state.
      tick();
      tick();
      chk("rst_flags", {25'd0, ready_out, addr_even_valid, addr_odd_valid, hit, pcd,
                        exception, walk_if.walk_req_valid}, 32'd0);
      chk("rst_addr_even", addr_even, 32'd0);
      chk("rst_addr_odd", addr_odd, 32'd0);
      chk("rst_walk_vpn", {12'd0, walk_if.walk_req_vpn}, 32'd0);
      rst = 1'b0;
      tick();

      // Cold miss, both lines in one page: exactly one walk.
      walk_exp.push_back(20'h00123);
      lookup(28'h0012345, 28'h0012346, f);
      chk("cold_addr_even", addr_even, 32'h000AB450);
      chk("cold_addr_odd", addr_odd, 32'h000AB460);
      chk("cold_hit", {31'd0, hit}, 32'd1);

      // Page split: even page walked first, then odd.
      do_flush();
      walk_exp.push_back(20'h00123);
      walk_exp.push_back(20'h00124);
      lookup(28'h00123FF, 28'h0012400, f);

      // Hit on an uncacheable-clear page, no walk.
      lookup(28'h0012410, 28'h0012420, f);

      // Stall after accept holds outputs and blocks a hitting request.
      stall_in    = 1'b1;
      valid_in    = 1'b1;
      clc_even_in = 28'h0012345;
      clc_odd_in  = 28'h0012346;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_ready", {31'd0, ready_out}, 32'd0);
         tick();
         chk("stall_valids", {30'd0, addr_even_valid, addr_odd_valid}, 32'd3);
         chk("stall_addr_even", addr_even, last_exp.ae);
         chk("stall_addr_odd", addr_odd, last_exp.ao);
      end
      stall_in = 1'b0;
      valid_in = 1'b0;
      tick();
      chk("idle_valids", {29'd0, addr_even_valid, addr_odd_valid, hit}, 32'd0);

      // Replacement: five pages into four entries, then re-accesses.
      do_flush();
      for (int p = 0; p < 5; p++) begin
         walk_exp.push_back(20'h00400 + 20'(p));
         lookup(line_of(20'h00400 + 20'(p), 8'h10), line_of(20'h00400 + 20'(p), 8'h20), f);
      end
      walk_exp.push_back(20'h00400);
      lookup(line_of(20'h00400, 8'h30), line_of(20'h00400, 8'h40), f);
      lookup(line_of(20'h00402, 8'h30), line_of(20'h00403, 8'h40), f);
      walk_exp.push_back(20'h00401);
      lookup(line_of(20'h00401, 8'h50), line_of(20'h00401, 8'h60), f);

      // Fault latch: exception, no further walks until flush.
      do_flush();
      walk_exp.push_back(20'h00200);
      lookup(line_of(20'h00200, 8'h10), line_of(20'h00200, 8'h20), f);
      chk("fault_seen", {31'd0, f}, 32'd1);
      chk("fault_exception", {31'd0, exception}, 32'd1);
      valid_in    = 1'b1;
      clc_even_in = line_of(20'h00200, 8'h10);
      clc_odd_in  = line_of(20'h00200, 8'h20);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("fault_no_walk", {30'd0, walk_if.walk_req_valid, ready_out}, 32'd0);
         chk("fault_held", {29'd0, exception, addr_even_valid, addr_odd_valid}, 32'd4);
      end
      valid_in = 1'b0;
      do_flush();
      chk("flush_clears_exception", {31'd0, exception}, 32'd0);

      // Flush during WAIT drops the response, including a late one.
      valid_in    = 1'b1;
      clc_even_in = line_of(20'h00300, 8'h10);
      clc_odd_in  = line_of(20'h00300, 8'h20);
      for (int i = 0; i < 20 && !walk_if.walk_req_valid; i++) begin
         tick();
      end
      chk("abort_walk_req", {31'd0, walk_if.walk_req_valid}, 32'd1);
      chk("abort_walk_vpn", {12'd0, walk_if.walk_req_vpn}, 32'h00300);
      walk_if.walk_req_ready = 1'b1;
      tick();
      walk_if.walk_req_ready  = 1'b0;
      valid_in                = 1'b0;
      flush_in                = 1'b1;
      walk_if.walk_resp_valid = 1'b1;
      walk_if.walk_resp_ppn   = 20'hDEAD0;
      walk_if.walk_resp_pcd   = 1'b0;
      walk_if.walk_resp_fault = 1'b0;
      tick();
      flush_in = 1'b0;
      tick();
      walk_if.walk_resp_valid = 1'b0;
      chk("abort_idle", {30'd0, walk_if.walk_req_valid, exception}, 32'd0);
      valid_in = 1'b1;
      #1;
      chk("abort_miss", {31'd0, ready_out}, 32'd0);
      walk_exp.push_back(20'h00300);
      lookup(line_of(20'h00300, 8'h10), line_of(20'h00300, 8'h20), f);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
